// File: rtl/uart_rx_ctrl_pkg.sv
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared state encoding and constants for the UART RX sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_rx_pkg;

  localparam int c_data_width  = 8;
  localparam int c_prescale_8  = 8;
  localparam int c_prescale_16 = 16;
  localparam int c_prescale_32 = 32;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  function automatic bit prescale_is_legal(input int prescale);
    return (prescale == c_prescale_8) || (prescale == c_prescale_16) ||
           (prescale == c_prescale_32);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
// ============================================================================
// Module      : uart_rx_ctrl_if
// Description : Line, checker and enable signals between the RX sequencer
//               and the RX datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_ctrl_if #(
  parameter int PRESCALE_W = 6
) ();

  logic                  RX_IN;
  logic                  PAR_EN;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  start_error;
  logic                  par_error;
  logic                  stop_error;

  logic [PRESCALE_W-1:0] edge_cnt;
  logic [3:0]            bit_cnt;
  logic                  data_samp_EN;
  logic                  start_check_EN;
  logic                  par_check_EN;
  logic                  stop_check_EN;
  logic                  deser_EN;
  logic                  data_valid;
  logic                  rx_error;

  // Sequencer side
  modport master (
    input  RX_IN, PAR_EN, Prescale, start_error, par_error, stop_error,
    output edge_cnt, bit_cnt, data_samp_EN, start_check_EN, par_check_EN,
           stop_check_EN, deser_EN, data_valid, rx_error
  );

  // Datapath / line side
  modport slave (
    output RX_IN, PAR_EN, Prescale, start_error, par_error, stop_error,
    input  edge_cnt, bit_cnt, data_samp_EN, start_check_EN, par_check_EN,
           stop_check_EN, deser_EN, data_valid, rx_error
  );

endinterface

`default_nettype wire

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// ============================================================================
// Module      : edge_bit_counter
// Description : Oversample (edge) and data-bit counters with bit-end flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module edge_bit_counter #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  wire logic                  CLK,
  input  wire logic                  Reset,
  input  wire logic                  enable,
  input  wire logic                  bit_inc_en,
  input  wire logic                  clear,
  input  wire logic [PRESCALE_W-1:0] Prescale,
  output logic      [PRESCALE_W-1:0] edge_cnt,
  output logic      [3:0]            bit_cnt,
  output logic                       bit_end
);

  localparam logic [3:0] c_bit_last = 4'(DATA_WIDTH - 1);

  logic [PRESCALE_W-1:0] w_edge_last;

  assign w_edge_last = Prescale - PRESCALE_W'(1);
  assign bit_end     = enable && (edge_cnt == w_edge_last);

  always_ff @(posedge CLK) begin
    if (Reset || clear) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (enable) begin
      if (bit_end) begin
        edge_cnt <= '0;
        if (bit_inc_en) begin
          bit_cnt <= (bit_cnt == c_bit_last) ? 4'd0 : bit_cnt + 4'd1;
        end
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
// ============================================================================
// Module      : uart_rx_ctrl
// Description : UART RX sequencer - frame FSM, checker/deserializer enables
//               and good/bad frame result pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = c_data_width,
  parameter int PRESCALE_W = 6
) (
  input  wire logic       CLK,
  input  wire logic       Reset,
  uart_rx_ctrl_if.master  bus
);

  localparam logic [3:0] c_bit_last = 4'(DATA_WIDTH - 1);

  rx_state_t r_state;
  rx_state_t w_next_state;

  logic [PRESCALE_W-1:0] w_edge_cnt;
  logic [3:0]            w_bit_cnt;
  logic                  w_bit_end;
  logic [PRESCALE_W-1:0] w_pre_check_pt;
  logic                  w_pre_check;
  logic                  w_frame_start;

  logic w_samp_nxt, w_start_chk_nxt, w_par_chk_nxt, w_stop_chk_nxt, w_deser_nxt;
  logic w_valid_nxt, w_err_nxt;

  logic r_par_en_q, r_par_fail;
  logic r_data_samp_EN, r_start_check_EN, r_par_check_EN, r_stop_check_EN;
  logic r_deser_EN, r_data_valid, r_rx_error;

  edge_bit_counter #(
    .DATA_WIDTH (DATA_WIDTH),
    .PRESCALE_W (PRESCALE_W)
  ) u_counter (
    .CLK        (CLK),
    .Reset      (Reset),
    .enable     (r_state != RX_IDLE),
    .bit_inc_en (r_state == RX_DATA),
    .clear      (r_state == RX_IDLE),
    .Prescale   (bus.Prescale),
    .edge_cnt   (w_edge_cnt),
    .bit_cnt    (w_bit_cnt),
    .bit_end    (w_bit_end)
  );

  // Enables are registered, so decode one cycle ahead of the check point H+2.
  assign w_pre_check_pt = (bus.Prescale >> 1) + PRESCALE_W'(1);
  assign w_pre_check    = (w_edge_cnt == w_pre_check_pt);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      RX_IDLE:   if (!bus.RX_IN) w_next_state = RX_START;
      RX_START:  if (w_bit_end) w_next_state = bus.start_error ? RX_IDLE : RX_DATA;
      RX_DATA:   if (w_bit_end && (w_bit_cnt == c_bit_last))
                   w_next_state = r_par_en_q ? RX_PARITY : RX_STOP;
      RX_PARITY: if (w_bit_end) w_next_state = RX_STOP;
      RX_STOP:   if (w_bit_end) w_next_state = bus.RX_IN ? RX_IDLE : RX_START;
      default:   w_next_state = RX_IDLE;
    endcase

    w_frame_start   = (w_next_state == RX_START) &&
                      ((r_state == RX_IDLE) || (r_state == RX_STOP));
    w_samp_nxt      = (w_next_state != RX_IDLE);
    w_start_chk_nxt = (r_state == RX_START)  && w_pre_check;
    w_deser_nxt     = (r_state == RX_DATA)   && w_pre_check;
    w_par_chk_nxt   = (r_state == RX_PARITY) && w_pre_check;
    w_stop_chk_nxt  = (r_state == RX_STOP)   && w_pre_check;
    w_valid_nxt     = (r_state == RX_STOP) && w_bit_end && !bus.stop_error && !r_par_fail;
    w_err_nxt       = (r_state == RX_STOP) && w_bit_end && (bus.stop_error || r_par_fail);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= RX_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_par_en_q       <= 1'b0;
      r_par_fail       <= 1'b0;
      r_data_samp_EN   <= 1'b0;
      r_start_check_EN <= 1'b0;
      r_par_check_EN   <= 1'b0;
      r_stop_check_EN  <= 1'b0;
      r_deser_EN       <= 1'b0;
      r_data_valid     <= 1'b0;
      r_rx_error       <= 1'b0;
    end else begin
      r_data_samp_EN   <= w_samp_nxt;
      r_start_check_EN <= w_start_chk_nxt;
      r_par_check_EN   <= w_par_chk_nxt;
      r_stop_check_EN  <= w_stop_chk_nxt;
      r_deser_EN       <= w_deser_nxt;
      r_data_valid     <= w_valid_nxt;
      r_rx_error       <= w_err_nxt;
      if (w_frame_start) begin
        r_par_en_q <= bus.PAR_EN;
      end
      if ((r_state == RX_PARITY) && w_bit_end) begin
        r_par_fail <= bus.par_error;
      end else if ((r_state == RX_STOP) && (w_next_state != RX_STOP)) begin
        r_par_fail <= 1'b0;
      end
    end
  end

  assign bus.edge_cnt       = w_edge_cnt;
  assign bus.bit_cnt        = w_bit_cnt;
  assign bus.data_samp_EN   = r_data_samp_EN;
  assign bus.start_check_EN = r_start_check_EN;
  assign bus.par_check_EN   = r_par_check_EN;
  assign bus.stop_check_EN  = r_stop_check_EN;
  assign bus.deser_EN       = r_deser_EN;
  assign bus.data_valid     = r_data_valid;
  assign bus.rx_error       = r_rx_error;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
// ============================================================================
// Module      : tb_uart_rx_ctrl
// Description : Self-checking bench for uart_rx_ctrl with a cycle-level
//               frame timing model and emulated registered checkers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_ctrl;
  import uart_rx_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic CLK   = 1'b0;
  logic Reset = 1'b1;
  int   cyc   = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic plan_start = 1'b0;
  logic plan_par   = 1'b0;
  logic plan_stop  = 1'b0;

  int got_sc[$], got_pc[$], got_stc[$], got_deser[$], got_deser_edge[$], got_dv[$], got_err[$];
  int exp_sc[$], exp_pc[$], exp_stc[$], exp_deser[$], exp_dv[$], exp_err[$];

  uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Registered checkers: report the planned verdict the cycle after their enable
  always @(posedge CLK) begin
    if (Reset) begin
      bus.start_error <= 1'b0;
      bus.par_error   <= 1'b0;
      bus.stop_error  <= 1'b0;
    end else begin
      if (bus.start_check_EN) bus.start_error <= plan_start;
      if (bus.par_check_EN)   bus.par_error   <= plan_par;
      if (bus.stop_check_EN)  bus.stop_error  <= plan_stop;
    end
  end

  always @(negedge CLK) begin
    if (!Reset) begin
      if (bus.start_check_EN) got_sc.push_back(cyc);
      if (bus.par_check_EN)   got_pc.push_back(cyc);
      if (bus.stop_check_EN)  got_stc.push_back(cyc);
      if (bus.deser_EN) begin
        got_deser.push_back(cyc);
        got_deser_edge.push_back(int'(bus.edge_cnt));
      end
      if (bus.data_valid) got_dv.push_back(cyc);
      if (bus.rx_error)   got_err.push_back(cyc);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d, required < 90000", cyc);
    $fatal(1, "watchdog");
  end

  function automatic bit q_eq(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int q_first(input int a[$]);
    return (a.size() == 0) ? -1 : a[0];
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    got_sc.delete(); got_pc.delete(); got_stc.delete(); got_deser.delete();
    got_deser_edge.delete(); got_dv.delete(); got_err.delete();
    exp_sc.delete(); exp_pc.delete(); exp_stc.delete(); exp_deser.delete();
    exp_dv.delete(); exp_err.delete();
  endtask

  // Frame timing from the line-sampling cycle k: bit b spans k+1+b*P .. k+(b+1)*P
  task automatic model_frame(input int k, input int p, input bit pe, input bit se,
                             input bit perr, input bit sterr);
    int n, h;
    n = 2 + DW + (pe ? 1 : 0);
    h = p / 2;
    exp_sc.push_back(k + 1 + h + 2);
    if (se) return;
    for (int i = 0; i < DW; i++) exp_deser.push_back(k + 1 + p * (1 + i) + h + 2);
    if (pe) exp_pc.push_back(k + 1 + p * (1 + DW) + h + 2);
    exp_stc.push_back(k + 1 + p * (n - 1) + h + 2);
    if ((pe && perr) || sterr) exp_err.push_back(k + 1 + n * p);
    else                       exp_dv.push_back(k + 1 + n * p);
  endtask

  // Drives one whole frame on RX_IN; returns on the last stop-bit cycle
  task automatic send_frame(input logic [7:0] data, input bit pe, input int p,
                            input bit perr, input bit sterr, output int k);
    int n;
    logic [15:0] bits;
    n = 2 + DW + (pe ? 1 : 0);
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < DW; i++) bits[1 + i] = data[i];
    if (pe) bits[1 + DW] = ^data;
    plan_start   = 1'b0;
    plan_par     = perr;
    plan_stop    = sterr;
    bus.Prescale = PW'(p);
    bus.PAR_EN   = pe;
    k = cyc;
    model_frame(k, p, pe, 1'b0, perr, sterr);
    for (int b = 0; b < n; b++) begin
      bus.RX_IN = bits[b];
      for (int c = 0; c < p; c++) begin
        step();
        if (b == 0 && c == 1) bus.PAR_EN = ~pe;
      end
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    bus.RX_IN = 1'b1;
    repeat (3) step();
    n_tests++;
    if ({bus.data_samp_EN, bus.start_check_EN, bus.par_check_EN, bus.stop_check_EN,
         bus.deser_EN, bus.data_valid, bus.rx_error} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000000", {bus.data_samp_EN,
               bus.start_check_EN, bus.par_check_EN, bus.stop_check_EN, bus.deser_EN,
               bus.data_valid, bus.rx_error});
    end
    n_tests++;
    if (bus.edge_cnt !== '0) begin
      n_fail++; $display("FAIL reset_edge_cnt: got %0d, required 0", bus.edge_cnt);
    end
    n_tests++;
    if (bus.bit_cnt !== 4'd0) begin
      n_fail++; $display("FAIL reset_bit_cnt: got %0d, required 0", bus.bit_cnt);
    end
    Reset = 1'b0;
    repeat (5) step();
    n_tests++;
    if (bus.data_samp_EN !== 1'b0 || bus.edge_cnt !== '0) begin
      n_fail++;
      $display("FAIL idle_hold: samp_EN %b edge_cnt %0d, required 0 and 0",
               bus.data_samp_EN, bus.edge_cnt);
    end
  endtask

  task automatic test_good_frame();
    int k, bad;
    clear_logs();
    send_frame(8'hA5, 1'b0, 8, 1'b0, 1'b0, k);
    repeat (3) step();
    n_tests++;
    if (!q_eq(got_deser, exp_deser)) begin
      n_fail++;
      $display("FAIL good_deser: got %0d pulses first@%0d, required %0d first@%0d",
               got_deser.size(), q_first(got_deser), exp_deser.size(), q_first(exp_deser));
    end
    bad = 0;
    foreach (got_deser_edge[i]) if (got_deser_edge[i] != 6) bad++;
    n_tests++;
    if (bad != 0 || got_deser_edge.size() != 8) begin
      n_fail++;
      $display("FAIL good_deser_edge: %0d of %0d pulses off edge 6, required 0 of 8",
               bad, got_deser_edge.size());
    end
    n_tests++;
    if (got_dv.size() != 1 || q_first(got_dv) != k + 81) begin
      n_fail++;
      $display("FAIL good_dv: got %0d pulses first@%0d, required 1 at %0d",
               got_dv.size(), q_first(got_dv), k + 81);
    end
    n_tests++;
    if (got_err.size() != 0) begin
      n_fail++; $display("FAIL good_no_err: got %0d rx_error pulses, required 0", got_err.size());
    end
    n_tests++;
    if (!q_eq(got_sc, exp_sc) || !q_eq(got_stc, exp_stc) || got_pc.size() != 0) begin
      n_fail++;
      $display("FAIL good_checks: start@%0d stop@%0d par=%0d, required start@%0d stop@%0d par=0",
               q_first(got_sc), q_first(got_stc), got_pc.size(), q_first(exp_sc), q_first(exp_stc));
    end
  endtask

  task automatic test_start_glitch();
    int k;
    clear_logs();
    bus.Prescale = PW'(8);
    bus.PAR_EN   = 1'b0;
    plan_start   = 1'b1;
    k = cyc;
    model_frame(k, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.RX_IN = 1'b0;
    repeat (2) step();
    bus.RX_IN = 1'b1;
    while (cyc < k + 8) step();
    n_tests++;
    if (bus.data_samp_EN !== 1'b1) begin
      n_fail++; $display("FAIL glitch_in_start: samp_EN %b at k+8, required 1", bus.data_samp_EN);
    end
    step();
    n_tests++;
    if (bus.data_samp_EN !== 1'b0 || bus.edge_cnt !== '0) begin
      n_fail++;
      $display("FAIL glitch_idle: samp_EN %b edge_cnt %0d at k+9, required 0 and 0",
               bus.data_samp_EN, bus.edge_cnt);
    end
    repeat (100) step();
    n_tests++;
    if (got_deser.size() != 0 || got_dv.size() != 0 || got_err.size() != 0 || !q_eq(got_sc, exp_sc)) begin
      n_fail++;
      $display("FAIL glitch_quiet: deser %0d dv %0d err %0d start@%0d, required 0 0 0 start@%0d",
               got_deser.size(), got_dv.size(), got_err.size(), q_first(got_sc), q_first(exp_sc));
    end
    plan_start = 1'b0;
  endtask

  task automatic test_parity_fail();
    int k;
    clear_logs();
    send_frame(8'($urandom), 1'b1, 16, 1'b1, 1'b0, k);
    repeat (3) step();
    n_tests++;
    if (got_err.size() != 1 || q_first(got_err) != k + 177 || got_dv.size() != 0) begin
      n_fail++;
      $display("FAIL parity_err: rx_error %0d first@%0d dv %0d, required 1 at %0d dv 0",
               got_err.size(), q_first(got_err), got_dv.size(), k + 177);
    end
    n_tests++;
    if (!q_eq(got_pc, exp_pc)) begin
      n_fail++;
      $display("FAIL parity_check_en: got %0d first@%0d, required %0d first@%0d",
               got_pc.size(), q_first(got_pc), exp_pc.size(), q_first(exp_pc));
    end
  endtask

  task automatic test_stop_fail();
    int k;
    clear_logs();
    send_frame(8'($urandom), 1'b0, 32, 1'b0, 1'b1, k);
    repeat (2) step();
    n_tests++;
    if (got_err.size() != 1 || q_first(got_err) != k + 321 || got_dv.size() != 0) begin
      n_fail++;
      $display("FAIL stop_err: rx_error %0d first@%0d dv %0d, required 1 at %0d dv 0",
               got_err.size(), q_first(got_err), got_dv.size(), k + 321);
    end
    n_tests++;
    if (bus.data_samp_EN !== 1'b0) begin
      n_fail++; $display("FAIL stop_idle: samp_EN %b after frame, required 0", bus.data_samp_EN);
    end
  endtask

  task automatic test_back_to_back();
    int k1, k2;
    clear_logs();
    send_frame(8'($urandom), 1'b1, 16, 1'b0, 1'b0, k1);
    send_frame(8'($urandom), 1'b1, 16, 1'b0, 1'b0, k2);
    repeat (3) step();
    n_tests++;
    if (got_dv.size() != 2 || !q_eq(got_dv, exp_dv) || (got_dv[1] - got_dv[0]) != 176) begin
      n_fail++;
      $display("FAIL b2b_dv: got %0d pulses first@%0d, required 2 at %0d and %0d",
               got_dv.size(), q_first(got_dv), k1 + 177, k1 + 353);
    end
    n_tests++;
    if (!q_eq(got_pc, exp_pc) || got_err.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_parity: par checks %0d err %0d, required %0d and 0",
               got_pc.size(), got_err.size(), exp_pc.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    int k, guard;
    clear_logs();
    bus.Prescale = PW'(8);
    bus.PAR_EN   = 1'b0;
    bus.RX_IN    = 1'b0;
    step();
    bus.RX_IN = 1'b1;
    guard = 0;
    while (!(bus.data_samp_EN === 1'b1 && bus.bit_cnt === 4'd3) && guard < 200) begin
      step();
      guard++;
    end
    n_tests++;
    if (guard >= 200) begin
      n_fail++; $display("FAIL rst_mid_reach: bit_cnt %0d after 200 cycles, required 3", bus.bit_cnt);
    end
    Reset = 1'b1;
    step();
    n_tests++;
    if ({bus.data_samp_EN, bus.start_check_EN, bus.par_check_EN, bus.stop_check_EN,
         bus.deser_EN, bus.data_valid, bus.rx_error} !== 7'b0 ||
        bus.edge_cnt !== '0 || bus.bit_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: flags %b edge %0d bit %0d, required all 0",
               {bus.data_samp_EN, bus.start_check_EN, bus.par_check_EN, bus.stop_check_EN,
                bus.deser_EN, bus.data_valid, bus.rx_error}, bus.edge_cnt, bus.bit_cnt);
    end
    Reset = 1'b0;
    repeat (20) step();
    n_tests++;
    if (bus.data_samp_EN !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_idle: samp_EN %b with line high, required 0", bus.data_samp_EN);
    end
    clear_logs();
    send_frame(8'h3C, 1'b0, 8, 1'b0, 1'b0, k);
    repeat (3) step();
    n_tests++;
    if (got_dv.size() != 1 || q_first(got_dv) != k + 81 || got_err.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_next: dv %0d first@%0d err %0d, required 1 at %0d err 0",
               got_dv.size(), q_first(got_dv), got_err.size(), k + 81);
    end
  endtask

  task automatic test_random();
    int k, p, gap, legal_p[3];
    bit pe;
    legal_p = '{c_prescale_8, c_prescale_16, c_prescale_32};
    clear_logs();
    p = legal_p[$urandom_range(0, 2)];
    for (int f = 0; f < 10; f++) begin
      gap = $urandom_range(0, 3);
      if (f > 0 && gap > 0) begin
        repeat (gap) step();
        p = legal_p[$urandom_range(0, 2)];
      end
      pe = 1'($urandom);
      send_frame(8'($urandom), pe, p, 1'($urandom), ($urandom_range(0, 3) == 0), k);
    end
    repeat (3) step();
    n_tests++;
    if (!prescale_is_legal(int'(bus.Prescale))) begin
      n_fail++; $display("FAIL rand_prescale: drove %0d, required 8/16/32", bus.Prescale);
    end
    n_tests++;
    if (!q_eq(got_dv, exp_dv) || !q_eq(got_err, exp_err)) begin
      n_fail++;
      $display("FAIL rand_results: dv %0d err %0d, required dv %0d err %0d",
               got_dv.size(), got_err.size(), exp_dv.size(), exp_err.size());
    end
    n_tests++;
    if (!q_eq(got_deser, exp_deser) || !q_eq(got_pc, exp_pc) ||
        !q_eq(got_stc, exp_stc) || !q_eq(got_sc, exp_sc)) begin
      n_fail++;
      $display("FAIL rand_enables: deser %0d par %0d stop %0d start %0d, required %0d %0d %0d %0d",
               got_deser.size(), got_pc.size(), got_stc.size(), got_sc.size(),
               exp_deser.size(), exp_pc.size(), exp_stc.size(), exp_sc.size());
    end
  endtask

  initial begin
    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.Prescale = PW'(8);
    step();
    test_reset();
    test_good_frame();
    repeat (4) step();
    test_start_glitch();
    test_parity_fail();
    repeat (4) step();
    test_stop_fail();
    repeat (4) step();
    test_back_to_back();
    repeat (4) step();
    test_reset_mid_frame();
    repeat (4) step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
